// File: rtl/mult_pipe_pkg.sv
// Shared types and sizing helpers for the pipelined MULT/MULTU unit.
package mult_pkg;

    typedef enum logic {
        MULTU = 1'b0,
        MULT  = 1'b1
    } mult_op_e;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_TAG_W  = 5;

    // Multiplier bits consumed by each stage for the default configuration.
    localparam int ROWS_PER_STAGE = DEF_WIDTH / DEF_STAGES;

    // Contents of one stage register at the default configuration.
    typedef struct packed {
        logic                     valid;
        logic                     neg;
        logic [DEF_WIDTH-1:0]     a_mag;
        logic [DEF_WIDTH-1:0]     b_mag;
        logic [2*DEF_WIDTH-1:0]   acc;
        logic [DEF_TAG_W-1:0]     tag;
    } mult_stage_t;

    // Multiplier bits consumed by each stage for an arbitrary configuration.
    function automatic int rows_per_stage(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/mult_pp_stage.sv
// One multiplier pipeline stage: adds R partial-product rows into the
// accumulator and registers the result with a global stall and flush.
// The last stage also applies the sign so the unit outputs leave a register.
module mult_pp_stage
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W,
    parameter int R     = ROWS_PER_STAGE,
    parameter int BASE  = 0,
    parameter bit LAST  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stall,
    input  logic               in_valid,
    input  logic               in_neg,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2*WIDTH-1:0] in_acc,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    output logic               out_neg,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [2*WIDTH-1:0] out_acc,
    output logic [TAG_W-1:0]   out_tag
);

    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] row;
    logic [WIDTH-1:0]   bits;

    // Accumulate rows for multiplier bits [BASE +: R]; negate the full product on the last stage.
    always_comb begin
        sum  = in_acc;
        row  = {{WIDTH{1'b0}}, in_a} << BASE;
        bits = in_b >> BASE;
        for (int i = 0; i < R; i++) begin
            if (bits[0]) begin
                sum = sum + row;
            end else begin
                sum = sum;
            end
            row  = row << 1;
            bits = bits >> 1;
        end
        if (LAST && in_neg) begin
            sum = ~sum + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            sum = sum;
        end
    end

    // Stage register: reset zeroes everything, flush kills the op, stall holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_neg   <= 1'b0;
            out_a     <= {WIDTH{1'b0}};
            out_b     <= {WIDTH{1'b0}};
            out_acc   <= {(2*WIDTH){1'b0}};
            out_tag   <= {TAG_W{1'b0}};
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_neg   <= in_neg;
            out_a     <= in_a;
            out_b     <= in_b;
            out_acc   <= sum;
            out_tag   <= in_tag;
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined MULT/MULTU unit: one op per cycle, STAGES-cycle latency,
// global stall on output backpressure, flush kills all in-flight ops.
// in_ready depends combinationally on out_ready (stall = out_valid & ~out_ready).
module mult_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int R = rows_per_stage(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("mult_pipe: STAGES must be in 1..WIDTH and divide WIDTH");
    end

    logic             stall;
    mult_op_e         op;
    logic             s0_valid;
    logic             s0_neg;
    logic [WIDTH-1:0] s0_a;
    logic [WIDTH-1:0] s0_b;

    logic [STAGES-1:0]  v;
    logic [STAGES-1:0]  ng;
    logic [WIDTH-1:0]   am [STAGES];
    logic [WIDTH-1:0]   bm [STAGES];
    logic [2*WIDTH-1:0] ac [STAGES];
    logic [TAG_W-1:0]   tg [STAGES];

    assign stall    = v[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    // Sign conditioning: magnitudes of signed operands and the product sign.
    always_comb begin
        op       = mult_op_e'(in_signed);
        s0_valid = in_valid & in_ready;
        if (op == MULT) begin
            s0_a   = in_a[WIDTH-1] ? (~in_a + {{(WIDTH-1){1'b0}}, 1'b1}) : in_a;
            s0_b   = in_b[WIDTH-1] ? (~in_b + {{(WIDTH-1){1'b0}}, 1'b1}) : in_b;
            s0_neg = in_a[WIDTH-1] ^ in_b[WIDTH-1];
        end else begin
            s0_a   = in_a;
            s0_b   = in_b;
            s0_neg = 1'b0;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic               iv;
        logic               ineg;
        logic [WIDTH-1:0]   ia;
        logic [WIDTH-1:0]   ib;
        logic [2*WIDTH-1:0] iacc;
        logic [TAG_W-1:0]   itag;

        if (k == 0) begin : g_first
            assign iv   = s0_valid;
            assign ineg = s0_neg;
            assign ia   = s0_a;
            assign ib   = s0_b;
            assign iacc = {(2*WIDTH){1'b0}};
            assign itag = in_tag;
        end else begin : g_next
            assign iv   = v[k-1];
            assign ineg = ng[k-1];
            assign ia   = am[k-1];
            assign ib   = bm[k-1];
            assign iacc = ac[k-1];
            assign itag = tg[k-1];
        end

        mult_pp_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .R     (R),
            .BASE  (k * R),
            .LAST  (k == STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .stall     (stall),
            .in_valid  (iv),
            .in_neg    (ineg),
            .in_a      (ia),
            .in_b      (ib),
            .in_acc    (iacc),
            .in_tag    (itag),
            .out_valid (v[k]),
            .out_neg   (ng[k]),
            .out_a     (am[k]),
            .out_b     (bm[k]),
            .out_acc   (ac[k]),
            .out_tag   (tg[k])
        );
    end

    assign out_valid = v[STAGES-1];
    assign out_hi    = ac[STAGES-1][2*WIDTH-1:WIDTH];
    assign out_lo    = ac[STAGES-1][WIDTH-1:0];
    assign out_tag   = tg[STAGES-1];
    assign busy      = |v;

endmodule
